// File: rtl/spi_peripheral_if.sv
// CPU-side register bus bundle for spi_peripheral.
// One access is one i_clk cycle with cs=1; rwb=1 reads, rwb=0 writes wdata into addr.
// rdata follows addr combinationally whether or not cs is high.
// A read of addr 0 with cs=1 also pops the RX head on that clock edge.
interface spi_peripheral_if;
   logic       cs;
   logic       rwb;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irqb;

   modport master (output cs, rwb, addr, wdata, input rdata, irqb);
   modport slave  (input cs, rwb, addr, wdata, output rdata, irqb);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target (MSB first, 8-bit frames) with a small CPU register bus.
// Define SPI_PERIPHERAL_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX is a single-byte buffer.
module spi_peripheral #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rstb,
   input  logic       i_cs,
   input  logic       i_rwb,
   input  logic [1:0] i_addr,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_irqb,
   input  logic       i_spi_cs_n,
   input  logic       i_spi_clk,
   input  logic       i_spi_mosi,
   output logic       o_spi_miso,
   output logic       o_spi_miso_oe
);

   typedef enum logic [1:0] {ST_RST, ST_ARM, ST_IDLE, ST_ACTIVE} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   cs_dly_q, cs_dly_d, sck_dly_q, sck_dly_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [6:0]             shift_in_q, shift_in_d;
   logic [7:0]             shift_out_q, shift_out_d;
   logic [7:0]             tx_buf_q, tx_buf_d;
   logic                   tx_empty_q, tx_empty_d;
   logic                   overrun_q, overrun_d;
   logic                   ie_rx_q, ie_rx_d, ie_ovr_q, ie_ovr_d;
   logic                   irqb_q, irqb_d;

   logic       cs_n_s, sck_s, mosi_s, cs_fall, cs_rise, sck_rise, sck_fall;
   logic       tx_load, push, pop, wr_tx, wr_ctl;
   logic       rx_valid, rx_full, push_ok;
   logic [7:0] push_byte, rx_head;
   logic [3:0] rx_count;
   logic       cs_active;

   assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
   assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_spi_clk};
   assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
   assign cs_n_s      = cs_sync_q[SYNC_STAGES-1];
   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign cs_dly_d    = cs_n_s;
   assign sck_dly_d   = sck_s;
   assign cs_fall     = cs_dly_q & ~cs_n_s;
   assign cs_rise     = ~cs_dly_q & cs_n_s;
   assign sck_rise    = ~sck_dly_q & sck_s;
   assign sck_fall    = sck_dly_q & ~sck_s;
   assign push_byte   = {shift_in_q, mosi_s};
   assign cs_active   = (state_q == ST_ACTIVE);

   assign wr_tx  = i_cs & ~i_rwb & (i_addr == 2'd1);
   assign wr_ctl = i_cs & ~i_rwb & (i_addr == 2'd3);
   assign pop    = i_cs & i_rwb & (i_addr == 2'd0) & rx_valid;

   // Reset pre-loads the CS chain high, so ST_RST spends one cycle letting a real sample enter
   // before ST_ARM may trust an all-high chain; a frame already running at release is skipped.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      tx_load     = 1'b0;
      push        = 1'b0;
      case (state_q)
         ST_RST:  state_d = ST_ARM;
         ST_ARM:  if ((&cs_sync_q) && cs_dly_q) state_d = ST_IDLE;
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = 3'd0;
               tx_load   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
            end else if (sck_rise) begin
               shift_in_d = {shift_in_q[5:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  push    = 1'b1;
                  tx_load = 1'b1;
               end
            end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
               // The falling edge after a byte boundary must keep the freshly loaded MSB.
               shift_out_d = {shift_out_q[6:0], 1'b1};
            end
         end
         default: state_d = ST_RST;
      endcase
      if (tx_load) shift_out_d = tx_empty_q ? 8'hFF : tx_buf_q;
   end

   always_comb begin
      tx_buf_d   = wr_tx ? i_data : tx_buf_q;
      tx_empty_d = tx_empty_q;
      if (wr_tx)        tx_empty_d = 1'b0;
      else if (tx_load) tx_empty_d = 1'b1;
      ie_rx_d    = wr_ctl ? i_data[0] : ie_rx_q;
      ie_ovr_d   = wr_ctl ? i_data[1] : ie_ovr_q;
      overrun_d  = (overrun_q & ~(wr_ctl & i_data[7])) | (push & rx_full & ~pop);
      irqb_d     = ~((ie_rx_q & rx_valid) | (ie_ovr_q & overrun_q));
      push_ok    = push & (~rx_full | pop);
   end

`ifdef SPI_PERIPHERAL_RX_FIFO_EN
   logic [7:0] rx_mem_q [4];
   logic [7:0] rx_mem_d [4];
   logic [1:0] rx_rd_ptr_q, rx_rd_ptr_d, rx_wr_ptr;
   logic [2:0] rx_cnt_q, rx_cnt_d;

   assign rx_valid  = (rx_cnt_q != 3'd0);
   assign rx_full   = (rx_cnt_q == 3'd4);
   assign rx_head   = rx_mem_q[rx_rd_ptr_q];
   assign rx_count  = {1'b0, rx_cnt_q};
   // On a full FIFO with a pop, this slot is the one being popped.
   assign rx_wr_ptr = rx_rd_ptr_q + rx_cnt_q[1:0];

   always_comb begin
      rx_mem_d    = rx_mem_q;
      rx_rd_ptr_d = rx_rd_ptr_q;
      rx_cnt_d    = rx_cnt_q;
      if (push_ok) rx_mem_d[rx_wr_ptr] = push_byte;
      if (pop) rx_rd_ptr_d = rx_rd_ptr_q + 2'd1;
      if (push_ok && !pop)      rx_cnt_d = rx_cnt_q + 3'd1;
      else if (!push_ok && pop) rx_cnt_d = rx_cnt_q - 3'd1;
   end

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         for (int i = 0; i < 4; i++) rx_mem_q[i] <= 8'h00;
         rx_rd_ptr_q <= 2'd0;
         rx_cnt_q    <= 3'd0;
      end else begin
         rx_mem_q    <= rx_mem_d;
         rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_cnt_q    <= rx_cnt_d;
      end
   end
`else
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;

   assign rx_valid = rx_valid_q;
   assign rx_full  = rx_valid_q;
   assign rx_head  = rx_data_q;
   assign rx_count = {3'b000, rx_valid_q};

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      if (push_ok) begin
         rx_data_d  = push_byte;
         rx_valid_d = 1'b1;
      end else if (pop) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end
`endif

   always_comb begin
      case (i_addr)
         2'd0:    o_data = rx_valid ? rx_head : 8'h00;
         2'd1:    o_data = tx_buf_q;
         2'd2:    o_data = {rx_count, cs_active, overrun_q, tx_empty_q, rx_valid};
         default: o_data = {6'b000000, ie_ovr_q, ie_rx_q};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         state_q     <= ST_RST;
         cs_sync_q   <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_dly_q    <= 1'b1;
         sck_dly_q   <= 1'b0;
         bit_cnt_q   <= 3'd0;
         shift_in_q  <= 7'd0;
         shift_out_q <= 8'hFF;
         tx_buf_q    <= 8'h00;
         tx_empty_q  <= 1'b1;
         overrun_q   <= 1'b0;
         ie_rx_q     <= 1'b0;
         ie_ovr_q    <= 1'b0;
         irqb_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cs_sync_q   <= cs_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_dly_q    <= cs_dly_d;
         sck_dly_q   <= sck_dly_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         tx_buf_q    <= tx_buf_d;
         tx_empty_q  <= tx_empty_d;
         overrun_q   <= overrun_d;
         ie_rx_q     <= ie_rx_d;
         ie_ovr_q    <= ie_ovr_d;
         irqb_q      <= irqb_d;
      end
   end

   assign o_irqb        = irqb_q;
   assign o_spi_miso    = shift_out_q[7];
   assign o_spi_miso_oe = cs_active;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as CPU on the register bus and as SPI mode-0 master.
module tb_spi_peripheral;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_peripheral_if bus ();
   logic spi_cs_n, spi_clk, spi_mosi;
   logic spi_miso, spi_miso_oe;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   spi_peripheral #(.SYNC_STAGES(2)) dut (
      .i_clk         (clk),
      .i_rstb        (rst_n),
      .i_cs          (bus.cs),
      .i_rwb         (bus.rwb),
      .i_addr        (bus.addr),
      .i_data        (bus.wdata),
      .o_data        (bus.rdata),
      .o_irqb        (bus.irqb),
      .i_spi_cs_n    (spi_cs_n),
      .i_spi_clk     (spi_clk),
      .i_spi_mosi    (spi_mosi),
      .o_spi_miso    (spi_miso),
      .o_spi_miso_oe (spi_miso_oe)
   );

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.rwb = 1'b0; bus.addr = a; bus.wdata = d;
      @(negedge clk);
      bus.cs = 1'b0; bus.rwb = 1'b1;
   endtask

   task automatic bus_pop(output logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.rwb = 1'b1; bus.addr = 2'd0;
      #1 d = bus.rdata;
      @(negedge clk);
      bus.cs = 1'b0;
   endtask

   task automatic bus_peek(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b0; bus.addr = a;
      #1 d = bus.rdata;
   endtask

   task automatic spi_select();
      wait_clks(1);
      spi_cs_n = 1'b0;
      wait_clks(6);
   endtask

   task automatic spi_deselect();
      wait_clks(4);
      spi_cs_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      wait_clks(4);
      m = spi_miso;
      spi_clk = 1'b1;
      wait_clks(4);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], m);
         rx[i] = m;
      end
   endtask

   task automatic spi_frame(input logic [7:0] tx, output logic [7:0] rx);
      spi_select();
      spi_byte(tx, rx);
      spi_deselect();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d;
      checks++; if (bus.irqb !== 1'b1) begin failures++; $display("FAIL reset_irqb got=%b exp=1", bus.irqb); end
      checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
      checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", spi_miso); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL reset_status got=%h exp=02", d); end
      bus_peek(2'd0, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", d); end
      bus_peek(2'd1, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", d); end
      bus_peek(2'd3, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", d); end
   endtask

   task automatic test_tx_rx();
      logic [7:0] d, rx;
      bus_write(2'd1, 8'hA5);
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL txrx_status_pre got=%h exp=00", d); end
      bus_peek(2'd1, d);
      checks++; if (d !== 8'hA5) begin failures++; $display("FAIL txrx_txreg got=%h exp=a5", d); end
      spi_select();
      checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL txrx_oe got=%b exp=1", spi_miso_oe); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h0A) begin failures++; $display("FAIL txrx_status_active got=%h exp=0a", d); end
      spi_byte(8'h3C, rx);
      spi_deselect();
      checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL txrx_miso got=%h exp=a5", rx); end
      checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL txrx_oe_off got=%b exp=0", spi_miso_oe); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h13) begin failures++; $display("FAIL txrx_status_post got=%h exp=13", d); end
      bus_pop(d);
      checks++; if (d !== 8'h3C) begin failures++; $display("FAIL txrx_rx got=%h exp=3c", d); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL txrx_status_empty got=%h exp=02", d); end
   endtask

   task automatic test_idle_ff();
      logic [7:0] d, rx;
      spi_frame(8'h00, rx);
      checks++; if (rx !== 8'hFF) begin failures++; $display("FAIL idle_miso got=%h exp=ff", rx); end
      bus_pop(d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL idle_rx got=%h exp=00", d); end
   endtask

   task automatic test_irq();
      logic [7:0] d, rx;
      logic m, seen;
      bus_write(2'd3, 8'h01);
      bus_peek(2'd3, d);
      checks++; if (d !== 8'h01) begin failures++; $display("FAIL irq_ctrl got=%h exp=01", d); end
      spi_select();
      for (int i = 7; i >= 1; i--) spi_bit(((8'h81 >> i) & 8'h01) != 8'h00, m);
      spi_mosi = 1'b1;
      wait_clks(4);
      spi_clk = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         bus.addr = 2'd2;
         #1;
         if (bus.rdata[0]) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL irq_push_timeout got=%b exp=1", seen); end
      checks++; if (bus.irqb !== 1'b1) begin failures++; $display("FAIL irq_latency got=%b exp=1", bus.irqb); end
      @(negedge clk);
      #1;
      checks++; if (bus.irqb !== 1'b0) begin failures++; $display("FAIL irq_assert got=%b exp=0", bus.irqb); end
      wait_clks(2);
      spi_clk = 1'b0;
      spi_deselect();
      bus_pop(d);
      checks++; if (d !== 8'h81) begin failures++; $display("FAIL irq_rx got=%h exp=81", d); end
      wait_clks(2);
      checks++; if (bus.irqb !== 1'b1) begin failures++; $display("FAIL irq_release got=%b exp=1", bus.irqb); end
      bus_write(2'd3, 8'h00);
      rx = 8'h00;
   endtask

   task automatic test_overrun();
      logic [7:0] d, rx;
`ifdef SPI_PERIPHERAL_RX_FIFO_EN
      logic [7:0] pat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) begin
         spi_frame(pat[i], rx);
         if (i < 4) exp_q.push_back(pat[i]);
      end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h47) begin failures++; $display("FAIL ovr_status got=%h exp=47", d); end
`else
      spi_frame(8'h11, rx);
      spi_frame(8'h22, rx);
      exp_q.push_back(8'h11);
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h17) begin failures++; $display("FAIL ovr_status got=%h exp=17", d); end
`endif
      bus_peek(2'd0, d);
      checks++; if (d !== 8'h11) begin failures++; $display("FAIL ovr_head got=%h exp=11", d); end
      bus_write(2'd3, 8'h02);
      wait_clks(2);
      checks++; if (bus.irqb !== 1'b0) begin failures++; $display("FAIL ovr_irq got=%b exp=0", bus.irqb); end
      bus_write(2'd3, 8'h80);
      bus_peek(2'd2, d);
`ifdef SPI_PERIPHERAL_RX_FIFO_EN
      checks++; if (d !== 8'h43) begin failures++; $display("FAIL ovr_clear got=%h exp=43", d); end
`else
      checks++; if (d !== 8'h13) begin failures++; $display("FAIL ovr_clear got=%h exp=13", d); end
`endif
      wait_clks(1);
      checks++; if (bus.irqb !== 1'b1) begin failures++; $display("FAIL ovr_irq_off got=%b exp=1", bus.irqb); end
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         bus_pop(d);
         checks++; if (d !== e) begin failures++; $display("FAIL ovr_rx got=%h exp=%h", d, e); end
      end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL ovr_drained got=%h exp=02", d); end
   endtask

   task automatic test_partial();
      logic [7:0] d, rx;
      logic m;
      spi_select();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
      spi_deselect();
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL partial_nopush got=%h exp=02", d); end
      spi_frame(8'h5A, rx);
      bus_pop(d);
      checks++; if (d !== 8'h5A) begin failures++; $display("FAIL partial_next_rx got=%h exp=5a", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d, rx;
      bus_write(2'd1, 8'h96);
      spi_select();
      bus_write(2'd1, 8'h69);
      spi_byte(8'hE7, rx);
      checks++; if (rx !== 8'h96) begin failures++; $display("FAIL b2b_miso0 got=%h exp=96", rx); end
      bus_pop(d);
      checks++; if (d !== 8'hE7) begin failures++; $display("FAIL b2b_rx0 got=%h exp=e7", d); end
      spi_byte(8'h18, rx);
      spi_deselect();
      checks++; if (rx !== 8'h69) begin failures++; $display("FAIL b2b_miso1 got=%h exp=69", rx); end
      bus_pop(d);
      checks++; if (d !== 8'h18) begin failures++; $display("FAIL b2b_rx1 got=%h exp=18", d); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL b2b_status got=%h exp=02", d); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d, rx;
      logic m;
      bus_write(2'd1, 8'h0F);
      bus_write(2'd3, 8'h03);
      spi_select();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
      checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL rstmid_oe_pre got=%b exp=1", spi_miso_oe); end
      checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL rstmid_miso_pre got=%b exp=0", spi_miso); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe got=%b exp=0", spi_miso_oe); end
      checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL rstmid_miso got=%b exp=1", spi_miso); end
      checks++; if (bus.irqb !== 1'b1) begin failures++; $display("FAIL rstmid_irqb got=%b exp=1", bus.irqb); end
      bus.addr = 2'd1;
      #1;
      checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rstmid_tx got=%h exp=00", bus.rdata); end
      bus.addr = 2'd3;
      #1;
      checks++; if (bus.rdata !== 8'h00) begin failures++; $display("FAIL rstmid_ctrl got=%h exp=00", bus.rdata); end
      wait_clks(2);
      rst_n = 1'b1;
      // CS stays low across release: the rest of this frame must be ignored.
      spi_byte(8'hFF, rx);
      checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_ignore_oe got=%b exp=0", spi_miso_oe); end
      bus_peek(2'd2, d);
      checks++; if (d !== 8'h02) begin failures++; $display("FAIL rstmid_ignore_status got=%h exp=02", d); end
      spi_deselect();
      spi_frame(8'hC5, rx);
      checks++; if (rx !== 8'hFF) begin failures++; $display("FAIL rstmid_after_miso got=%h exp=ff", rx); end
      bus_pop(d);
      checks++; if (d !== 8'hC5) begin failures++; $display("FAIL rstmid_after_rx got=%h exp=c5", d); end
   endtask

   // ---------------- sequence ----------------
   initial begin
      bus.cs = 1'b0; bus.rwb = 1'b1; bus.addr = 2'd0; bus.wdata = 8'h00;
      spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      rst_n = 1'b0;
      wait_clks(5);
      test_reset();
      rst_n = 1'b1;
      wait_clks(4);
      test_tx_rx();
      test_idle_ff();
      test_irq();
      test_overrun();
      test_partial();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
